lsm_sequencer: RTL and testbench
================================

Name: lsm_sequencer

Overview:
- Decode-stage micro-sequencer for PowerPC load/store-multiple (lmw, opcode 46; stmw, opcode 47).
- Accepts one instruction per handshake and expands lmw/stmw into one register-transfer micro-op per GPR, RT..31.
- Each micro-op carries a per-step effective-address offset: sign-extended D plus 4*i.
- Non-LSM instructions pass through as a single micro-op. Sits between fetch and the decode/immediate datapath.

Parameters:
- REGSZ, 32, width of the offset output (same meaning as the global register width).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush; abandons any sequence in progress.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  block can accept an instruction.
- in_instr  in  32  instruction word.
- uop_valid  out  1  micro-op valid.
- uop_ready  in  1  downstream accepts micro-op.
- uop_instr  out  32  latched original instruction word.
- uop_rt  out  5  GPR for this step.
- uop_ra  out  5  base register, instr[20:16].
- uop_offset  out  REGSZ  sign-extended D + 4*i, mod 2^REGSZ.
- uop_is_lsm  out  1  micro-op is an lmw/stmw step.
- uop_is_store  out  1  stmw step.
- uop_first  out  1  first micro-op of the instruction.
- uop_last  out  1  final micro-op of the instruction.
- uop_illegal  out  1  invalid lmw form detected.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, ISSUE.
- Reset (sync, highest priority):
  - state=IDLE, uop_valid=0, in_ready=1.
  - All uop_* data outputs = 0, busy=0.
- IDLE:
  - in_ready=1, uop_valid=0.
  - On in_valid & in_ready: latch instr, go to ISSUE. uop_valid=1 on the next cycle (1-cycle latency).
  - Initialise: rt=instr[25:21], offset=sext(instr[15:0]), first=1.
- ISSUE:
  - in_ready=0, uop_valid=1.
  - All uop_* outputs are registered and held stable while uop_valid & !uop_ready.
  - On uop_valid & uop_ready:
    - If uop_last: go to IDLE, uop_valid=0.
    - Otherwise: rt<=rt+1, offset<=offset+4 (REGSZ-bit wrap), first<=0.
- Throughput: one bubble cycle between instructions. in_ready is never asserted in ISSUE.
- uop_last:
  - Non-LSM or illegal micro-op: 1.
  - LSM: 1 when rt==31.
  - RT=31 gives a single micro-op with first=last=1.
- Pass-through (opcode not 46/47):
  - Single micro-op; uop_is_lsm=0, uop_is_store=0, uop_illegal=0.
  - uop_rt=instr[25:21], uop_ra=instr[20:16], uop_offset=sext(D); downstream ignores rt/offset.
- Illegal lmw:
  - Condition: opcode 46 and RA>=RT.
  - Behaviour: single micro-op; uop_illegal=1, uop_is_lsm=1, first=last=1. No expansion.
  - stmw is never illegal.
- The rt counter never wraps past 31; the last micro-op terminates the sequence.
- Offset arithmetic wraps modulo 2^REGSZ (D=0xFFFC, i=1 gives 0).
- flush (below reset, above everything else):
  - Next cycle: state=IDLE, uop_valid=0, in_ready=1.
  - An in_valid asserted in the flush cycle is not accepted.
  - A uop_ready handshake in the flush cycle is treated as not occurring for sequencing, but the downstream transfer is valid.
- Reset or flush mid-sequence: remaining steps are discarded; no partial-state carry-over.
- Handshake rules:
  - uop_valid never drops without uop_ready, except on reset/flush.
  - in_ready has no combinational dependence on in_valid.

Test Plan:
- lmw r29,-8(r1) (0xBBA1FFF8), uop_ready=1:
  - 3 micro-ops: rt=29,30,31; offset=0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; ra=1.
  - first on #1, last on #3; in_ready low throughout, high the cycle after.
- stmw r31,4(r1) (0xBFE10004) → single micro-op: rt=31, offset=4, is_store=1, first=last=1.
- stmw r30,0(r1) with uop_ready toggling 0,0,1,0,1:
  - Outputs stable while stalled.
  - Exactly 2 micro-ops (rt=30, 31), no duplicates or drops.
- lmw r3,0(r5) (0xB8650000) → single micro-op: uop_illegal=1, first=last=1, rt=3.
- addi r3,r4,1 (0x38640001) → single micro-op: is_lsm=0, last=1, offset=1.
- lmw r20,0(r1):
  - Flush after the 2nd micro-op: next cycle uop_valid=0, busy=0, in_ready=1.
  - A new stmw r31 then issues normally.
  - Repeat with reset in place of flush: all outputs at reset values.

Source files
------------

// File: rtl/lsm_sequencer.sv
// lsm_sequencer: decode-stage micro-sequencer that expands PowerPC lmw/stmw
// into one register-transfer micro-op per GPR (RT..31). Every other
// instruction passes through as a single micro-op. All outputs are registered.
module lsm_sequencer #(
  parameter int REGSZ = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             uop_valid,
  input  logic             uop_ready,
  output logic [31:0]      uop_instr,
  output logic [4:0]       uop_rt,
  output logic [4:0]       uop_ra,
  output logic [REGSZ-1:0] uop_offset,
  output logic             uop_is_lsm,
  output logic             uop_is_store,
  output logic             uop_first,
  output logic             uop_last,
  output logic             uop_illegal,
  output logic             busy
);

  localparam logic [5:0] OP_LMW  = 6'd46;
  localparam logic [5:0] OP_STMW = 6'd47;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t state_r;

  logic [5:0] op_s;
  logic [4:0] rt_s;
  logic [4:0] ra_s;
  logic       is_lsm_s;
  logic       is_store_s;
  logic       illegal_s;
  logic       last_s;

  // Sign-extend the 16-bit displacement to the offset width.
  function automatic logic [REGSZ-1:0] sext_d(input logic [15:0] d);
    return {{(REGSZ-16){d[15]}}, d};
  endfunction

  // Decode the incoming instruction word into the fields latched on accept.
  always_comb begin
    op_s       = in_instr[31:26];
    rt_s       = in_instr[25:21];
    ra_s       = in_instr[20:16];
    is_lsm_s   = 1'b0;
    is_store_s = 1'b0;
    illegal_s  = 1'b0;
    last_s     = 1'b1;
    if ((op_s == OP_LMW) || (op_s == OP_STMW)) begin
      is_lsm_s   = 1'b1;
      is_store_s = (op_s == OP_STMW);
      // lmw that would overwrite its own base register is an invalid form
      illegal_s  = (op_s == OP_LMW) && (ra_s >= rt_s);
      last_s     = illegal_s || (rt_s == 5'd31);
    end else begin
      is_lsm_s   = 1'b0;
      is_store_s = 1'b0;
      illegal_s  = 1'b0;
      last_s     = 1'b1;
    end
  end

  // Sequencer state machine; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      in_ready     <= 1'b1;
      uop_valid    <= 1'b0;
      busy         <= 1'b0;
      uop_instr    <= 32'd0;
      uop_rt       <= 5'd0;
      uop_ra       <= 5'd0;
      uop_offset   <= {REGSZ{1'b0}};
      uop_is_lsm   <= 1'b0;
      uop_is_store <= 1'b0;
      uop_first    <= 1'b0;
      uop_last     <= 1'b0;
      uop_illegal  <= 1'b0;
    end else if (flush) begin
      // Abandon the sequence; the next accept reloads every data field.
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      uop_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            state_r      <= ISSUE;
            in_ready     <= 1'b0;
            uop_valid    <= 1'b1;
            busy         <= 1'b1;
            uop_instr    <= in_instr;
            uop_rt       <= rt_s;
            uop_ra       <= ra_s;
            uop_offset   <= sext_d(in_instr[15:0]);
            uop_is_lsm   <= is_lsm_s;
            uop_is_store <= is_store_s;
            uop_first    <= 1'b1;
            uop_last     <= last_s;
            uop_illegal  <= illegal_s;
          end else begin
            in_ready  <= 1'b1;
            uop_valid <= 1'b0;
          end
        end
        ISSUE: begin
          if (uop_ready) begin
            if (uop_last) begin
              state_r   <= IDLE;
              in_ready  <= 1'b1;
              uop_valid <= 1'b0;
              busy      <= 1'b0;
            end else begin
              // Only legal LSM steps reach here, so rt stays below 31.
              uop_rt     <= uop_rt + 5'd1;
              uop_offset <= uop_offset + REGSZ'(3'd4);
              uop_first  <= 1'b0;
              uop_last   <= (uop_rt == 5'd30);
            end
          end else begin
            uop_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          uop_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsm_sequencer.sv
// Scoreboard bench for lsm_sequencer: a driver pushes the expected micro-op
// list for each instruction it issues, a monitor pops and compares on every
// downstream transfer and checks stability while stalled.
module tb_lsm_sequencer;

  localparam int REGSZ = 32;

  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  rt;
    logic [4:0]  ra;
    logic [31:0] offset;
    logic        is_lsm;
    logic        is_store;
    logic        first;
    logic        last;
    logic        illegal;
  } uop_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_instr = 32'd0;
  logic             uop_valid;
  logic             uop_ready = 1'b1;
  logic [31:0]      uop_instr;
  logic [4:0]       uop_rt;
  logic [4:0]       uop_ra;
  logic [REGSZ-1:0] uop_offset;
  logic             uop_is_lsm;
  logic             uop_is_store;
  logic             uop_first;
  logic             uop_last;
  logic             uop_illegal;
  logic             busy;

  int   checks = 0;
  int   failures = 0;
  bit   armed = 1'b0;
  bit   rand_mode = 1'b0;
  bit   pat[$];
  uop_t exp_q[$];
  uop_t prev_cap;
  bit   prev_stall = 1'b0;

  lsm_sequencer #(.REGSZ(REGSZ)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .uop_valid(uop_valid), .uop_ready(uop_ready),
    .uop_instr(uop_instr), .uop_rt(uop_rt), .uop_ra(uop_ra),
    .uop_offset(uop_offset), .uop_is_lsm(uop_is_lsm),
    .uop_is_store(uop_is_store), .uop_first(uop_first),
    .uop_last(uop_last), .uop_illegal(uop_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: the micro-op list an instruction must expand into.
  function automatic void push_model(input logic [31:0] ins);
    int   op, rt, ra, n;
    bit   lsm, ill;
    logic [31:0] base;
    uop_t e;
    op   = int'(ins[31:26]);
    rt   = int'(ins[25:21]);
    ra   = int'(ins[20:16]);
    base = {{16{ins[15]}}, ins[15:0]};
    lsm  = (op == 46) || (op == 47);
    ill  = (op == 46) && (ra >= rt);
    n    = (lsm && !ill) ? (32 - rt) : 1;
    for (int i = 0; i < n; i++) begin
      e.instr    = ins;
      e.rt       = 5'(rt + i);
      e.ra       = 5'(ra);
      e.offset   = base + 32'(4 * i);
      e.is_lsm   = lsm;
      e.is_store = (op == 47);
      e.first    = (i == 0);
      e.last     = (i == n - 1);
      e.illegal  = ill;
      exp_q.push_back(e);
    end
  endfunction

  function automatic uop_t capture();
    uop_t c;
    c.instr = uop_instr;   c.rt = uop_rt;             c.ra = uop_ra;
    c.offset = uop_offset; c.is_lsm = uop_is_lsm;     c.is_store = uop_is_store;
    c.first = uop_first;   c.last = uop_last;         c.illegal = uop_illegal;
    return c;
  endfunction

  // Downstream ready: scripted pattern first, then random or always-on.
  always @(posedge clk) begin
    #2;
    if (pat.size() > 0) uop_ready = pat.pop_front();
    else if (rand_mode) uop_ready = 1'($urandom_range(0, 1));
    else uop_ready = 1'b1;
  end

  // Monitor: handshake invariants, stall stability and scoreboard compare.
  always @(negedge clk) begin
    uop_t cur, e;
    if (armed) begin
      checks++;
      if (in_ready !== !uop_valid) begin
        failures++;
        $display("FAIL in_ready_vs_valid: in_ready=%b uop_valid=%b at %0t", in_ready, uop_valid, $time);
      end
      checks++;
      if (busy !== uop_valid) begin
        failures++;
        $display("FAIL busy_vs_valid: busy=%b uop_valid=%b at %0t", busy, uop_valid, $time);
      end
      if (uop_valid === 1'b1) begin
        cur = capture();
        if (prev_stall) begin
          checks++;
          if (cur !== prev_cap) begin
            failures++;
            $display("FAIL stall_stable: got rt=%0d off=%h now, held rt=%0d off=%h before, at %0t",
                     cur.rt, cur.offset, prev_cap.rt, prev_cap.offset, $time);
          end
        end
        if (uop_ready === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_uop: got instr=%h rt=%0d, expected none, at %0t", cur.instr, cur.rt, $time);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              failures++;
              $display("FAIL uop_compare: got instr=%h rt=%0d ra=%0d off=%h lsm=%b st=%b f=%b l=%b ill=%b, expected instr=%h rt=%0d ra=%0d off=%h lsm=%b st=%b f=%b l=%b ill=%b",
                       cur.instr, cur.rt, cur.ra, cur.offset, cur.is_lsm, cur.is_store, cur.first, cur.last, cur.illegal,
                       e.instr, e.rt, e.ra, e.offset, e.is_lsm, e.is_store, e.first, e.last, e.illegal);
            end
          end
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_cap   = cur;
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic send(input logic [31:0] ins);
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (in_ready === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL in_ready_timeout: in_ready=%b, expected 1 within 1000 cycles", in_ready);
    end else begin
      in_valid = 1'b1;
      in_instr = ins;
      push_model(ins);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && uop_valid === 1'b0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL drain_timeout: pending=%0d uop_valid=%b, expected 0 and 0", exp_q.size(), uop_valid);
    end
  endtask

  task automatic check_reset(input string name);
    checks++;
    if ({uop_valid, busy, uop_instr, uop_rt, uop_ra, uop_offset, uop_is_lsm,
         uop_is_store, uop_first, uop_last, uop_illegal} !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s: valid=%b busy=%b in_ready=%b instr=%h rt=%0d off=%h, expected all 0 with in_ready=1",
               name, uop_valid, busy, in_ready, uop_instr, uop_rt, uop_offset);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (uop_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s: valid=%b busy=%b in_ready=%b, expected 0 0 1", name, uop_valid, busy, in_ready);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus sequence: directed cases, flush/reset aborts, then random traffic.
  initial begin
    logic [31:0] ins;
    int op, rt, ra;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_values");
    reset = 1'b0;
    armed = 1'b1;

    send(32'hBBA1FFF8); drain(100);     // lmw r29,-8(r1)
    send(32'hBFE10004); drain(100);     // stmw r31,4(r1)
    send(32'hBFC10000);                 // stmw r30,0(r1) with stalls
    pat.push_back(1'b0); pat.push_back(1'b0); pat.push_back(1'b1);
    pat.push_back(1'b0); pat.push_back(1'b1);
    drain(100);
    send(32'hB8650000); drain(100);     // lmw r3,0(r5): illegal
    send(32'h38640001); drain(100);     // addi r3,r4,1
    send(32'hBFC0FFFC); drain(100);     // stmw r30,-4(r0): offset wraps to 0

    // Flush mid-sequence after two transfers.
    send(32'hBA810000);                 // lmw r20,0(r1)
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    check_idle("flush_idle");
    // Instruction offered during a flush cycle is dropped.
    in_valid = 1'b1; in_instr = 32'h38640001; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check_idle("flush_blocks_accept");
    send(32'hBFE10004); drain(100);

    // Same abort using reset.
    send(32'hBA810000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    check_reset("reset_midseq");
    send(32'hBFE10004); drain(100);

    // Random traffic with random downstream backpressure.
    rand_mode = 1'b1;
    for (int n = 0; n < 40; n++) begin
      ra = $urandom_range(0, 31);
      rt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(24, 31);
      case ($urandom_range(0, 3))
        0: op = 46;
        1: op = 47;
        2: begin
          op = $urandom_range(0, 63);
          if (op == 46 || op == 47) op = 14;
        end
        default: begin
          op = 46;
          rt = $urandom_range(1, 31);
          ra = $urandom_range(0, rt - 1);
        end
      endcase
      ins = {6'(op), 5'(rt), 5'(ra), 16'($urandom_range(0, 65535))};
      send(ins);
    end
    drain(5000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
